regfile_display_arbiter: RTL and testbench

Shares the register file's single debug-capable read port between the CPU datapath and the board's switch-driven register viewer. It synchronises and debounces the 5-bit switch index, and schedules viewer reads into cycles the CPU leaves idle, with a starvation bound. It latches the read value and drives one 7-segment digit (HEX4) with a selected nibble. It sits between the top-level board wrapper (sw, HEX4) and the register file.

---
 rtl/regfile_display_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_regfile_display_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_display_arbiter.sv
// regfile_display_arbiter
// Shares the register file's single read port between the CPU datapath and the
// board's switch-driven register viewer. The 5-bit switch index is
// synchronised and debounced. Viewer reads go into cycles the CPU leaves idle,
// with a starvation bound. An optional periodic refresh re-reads the displayed
// register. The captured value drives one active-low 7-segment digit.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high, clears all state
//   sw[4:0]      raw switch register index (asynchronous to clk)
//   nib_sel[2:0] nibble of disp_value shown on HEX4 (0 = bits 3:0)
//   cpu_rd_req   CPU requests the shared read port this cycle
//   cpu_rd_addr  CPU read index
//   cpu_rd_gnt   combinational; CPU owns the port this cycle
//   rf_raddr     combinational; register file read index
//   rf_rdata     register file read data (same cycle as rf_raddr)
//   disp_value   latched viewer value
//   disp_valid   high once at least one viewer read has completed
//   HEX4[6:0]    registered active-low segments {g,f,e,d,c,b,a}
module regfile_display_arbiter #(
  parameter int XLEN            = 32,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STARVE_LIMIT    = 8,
  parameter int REFRESH_CYCLES  = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      sw,
  input  logic [2:0]      nib_sel,
  input  logic            cpu_rd_req,
  input  logic [4:0]      cpu_rd_addr,
  output logic            cpu_rd_gnt,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic [XLEN-1:0] disp_value,
  output logic            disp_valid,
  output logic [6:0]      HEX4
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  endfunction

  logic [4:0]      sync1_r, sync2_r, prev_r, stable_idx_r;
  logic [DW-1:0]   db_cnt_r, db_cnt_next_s;
  logic            accept_s, wrap_s, force_s, viewer_rd_s, nib_ok_s;
  logic            pending_r, disp_valid_r;
  logic [SW-1:0]   starve_cnt_r;
  logic [XLEN-1:0] disp_value_r;
  logic [6:0]      hex_r;
  logic [3:0]      nib_s;

  // Two-flop synchroniser plus a one-cycle history of the synced index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 5'd0;
      sync2_r <= 5'd0;
      prev_r  <= 5'd0;
    end else begin
      sync1_r <= sw;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Debounce count: restarts at 1 whenever the synced index moves, so only an
  // index held unchanged for DEBOUNCE_CYCLES cycles is accepted.
  always_comb begin
    db_cnt_next_s = {DW{1'b0}};
    if (sync2_r == stable_idx_r) begin
      db_cnt_next_s = {DW{1'b0}};
    end else if (sync2_r != prev_r) begin
      db_cnt_next_s = DW'(1);
    end else begin
      db_cnt_next_s = db_cnt_r + DW'(1);
    end
    accept_s = (db_cnt_next_s == DW'(DEBOUNCE_CYCLES));
  end

  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      logic [RW-1:0] ref_cnt_r;
      assign wrap_s = (ref_cnt_r == RW'(REFRESH_CYCLES - 1));

      // Free-running refresh period counter.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ref_cnt_r <= {RW{1'b0}};
        end else if (wrap_s) begin
          ref_cnt_r <= {RW{1'b0}};
        end else begin
          ref_cnt_r <= ref_cnt_r + RW'(1);
        end
      end
    end else begin : g_no_refresh
      assign wrap_s = 1'b0;
    end
  endgenerate

  // Port arbitration: CPU wins unless the pending viewer read has waited
  // through STARVE_LIMIT consecutive CPU grants.
  always_comb begin
    force_s     = pending_r && (starve_cnt_r == SW'(STARVE_LIMIT));
    cpu_rd_gnt  = 1'b0;
    viewer_rd_s = 1'b0;
    rf_raddr    = cpu_rd_addr;
    if (cpu_rd_req && !force_s) begin
      cpu_rd_gnt = 1'b1;
      rf_raddr   = cpu_rd_addr;
    end else if (pending_r) begin
      viewer_rd_s = 1'b1;
      rf_raddr    = stable_idx_r;
    end else begin
      rf_raddr = cpu_rd_addr;
    end
  end

  // Viewer state: accepted index, pending request, starvation count, capture.
  // A new request raised in the same cycle as a viewer read keeps pending set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_idx_r <= 5'd0;
      db_cnt_r     <= {DW{1'b0}};
      pending_r    <= 1'b1;
      starve_cnt_r <= {SW{1'b0}};
      disp_value_r <= {XLEN{1'b0}};
      disp_valid_r <= 1'b0;
    end else begin
      db_cnt_r <= accept_s ? {DW{1'b0}} : db_cnt_next_s;
      if (accept_s) begin
        stable_idx_r <= sync2_r;
      end
      if (accept_s || wrap_s) begin
        pending_r <= 1'b1;
      end else if (viewer_rd_s) begin
        pending_r <= 1'b0;
      end
      if (viewer_rd_s) begin
        starve_cnt_r <= {SW{1'b0}};
        disp_value_r <= rf_rdata;
        disp_valid_r <= 1'b1;
      end else if (pending_r && cpu_rd_gnt && (starve_cnt_r != SW'(STARVE_LIMIT))) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end
    end
  end

  // Selected nibble; selections past the top nibble blank the digit.
  always_comb begin
    nib_ok_s = (32'(nib_sel) < 32'(XLEN / 4));
    nib_s    = 4'(disp_value_r >> {nib_sel, 2'b00});
  end

  // Registered segment driver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_r <= 7'b1000000;
    end else if (nib_ok_s) begin
      hex_r <= seg(nib_s);
    end else begin
      hex_r <= 7'b1111111;
    end
  end

  assign disp_value = disp_value_r;
  assign disp_valid = disp_valid_r;
  assign HEX4       = hex_r;

endmodule

// File: tb/tb_regfile_display_arbiter.sv
module tb_regfile_display_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sw;
  logic [2:0]  nib_sel;
  logic        cpu_rd_req;
  logic [4:0]  cpu_rd_addr;
  logic        cpu_rd_gnt;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] disp_value;
  logic        disp_valid;
  logic [6:0]  HEX4;

  logic [31:0] rf [32];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic [31:0] exp_dv_q[$];
  logic [6:0]  exp_hex_q[$];
  logic [31:0] last_dv = 32'd0;
  logic [6:0]  last_hex = 7'b1000000;

  regfile_display_arbiter #(
    .XLEN(32), .DEBOUNCE_CYCLES(4), .STARVE_LIMIT(8), .REFRESH_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .nib_sel(nib_sel),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_gnt(cpu_rd_gnt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .disp_value(disp_value),
    .disp_valid(disp_valid), .HEX4(HEX4)
  );

  always #5 clk = ~clk;
  assign rf_rdata = rf[rf_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick(1);
  endtask

  // Monitor: every change of disp_value or HEX4 must match the next expected entry.
  always @(negedge clk) begin
    if (reset) begin
      last_dv  = 32'd0;
      last_hex = 7'b1000000;
    end else begin
      if (disp_value !== last_dv) begin
        if (exp_dv_q.size() == 0) begin
          checks++;
          $display("FAIL disp_value unexpected change: got %h previous %h", disp_value, last_dv);
        end else begin
          check("disp_value", disp_value, exp_dv_q.pop_front());
        end
        last_dv = disp_value;
      end
      if (HEX4 !== last_hex) begin
        if (exp_hex_q.size() == 0) begin
          checks++;
          $display("FAIL HEX4 unexpected change: got %b previous %b", HEX4, last_hex);
        end else begin
          check("HEX4", 32'(HEX4), 32'(exp_hex_q.pop_front()));
        end
        last_hex = HEX4;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    reset = 1'b1; sw = 5'd0; nib_sel = 3'd0; cpu_rd_req = 1'b0; cpu_rd_addr = 5'd31;
    tick(2);
    // 1. reset state, then the x0 read on the first idle cycle
    check("reset disp_valid", 32'(disp_valid), 32'd0);
    check("reset disp_value", disp_value, 32'd0);
    check("reset HEX4", 32'(HEX4), 32'h40);
    check("reset gnt", 32'(cpu_rd_gnt), 32'd0);
    reset = 1'b0; cyc = 0; #1;
    check("first raddr x0", 32'(rf_raddr), 32'd0);
    check("first gnt", 32'(cpu_rd_gnt), 32'd0);
    tick(1);
    check("first disp_valid", 32'(disp_valid), 32'd1);

    // 3. glitch: sw=1 for two cycles, no viewer read may follow
    rf[1] = 32'h11; sw = 5'd1;
    tick(2);
    sw = 5'd0;
    for (int i = 0; i < 8; i++) begin
      check("glitch idle raddr", 32'(rf_raddr), 32'd31);
      tick(1);
    end

    // 2. clean change to x13, accepted 2+4 cycles after the edge
    wait_to(11);
    rf[13] = 32'h0000_00A5; sw = 5'd13;
    exp_dv_q.push_back(32'hA5);
    exp_hex_q.push_back(7'b0010010);
    tick(5);
    check("pre-accept raddr", 32'(rf_raddr), 32'd31);
    tick(1);
    check("accept raddr x13", 32'(rf_raddr), 32'd13);
    check("accept gnt", 32'(cpu_rd_gnt), 32'd0);
    tick(3);
    exp_hex_q.push_back(7'b0001000);
    nib_sel = 3'd1;
    tick(2);

    // 4. starvation: CPU busy, viewer forced after 8 grants
    wait_to(66);
    rf[11] = 32'd5; rf[20] = 32'h2020; sw = 5'd11; cpu_rd_req = 1'b1; cpu_rd_addr = 5'd20;
    exp_dv_q.push_back(32'd5);
    exp_hex_q.push_back(7'b1000000);
    wait_to(72);
    for (int i = 0; i < 8; i++) begin
      check("starve gnt", 32'(cpu_rd_gnt), 32'd1);
      check("starve raddr", 32'(rf_raddr), 32'd20);
      tick(1);
    end
    check("forced gnt", 32'(cpu_rd_gnt), 32'd0);
    check("forced raddr", 32'(rf_raddr), 32'd11);
    tick(1);
    check("regrant gnt", 32'(cpu_rd_gnt), 32'd1);
    check("forced capture", disp_value, 32'd5);

    // 5. refresh picks up a changed register without switch activity
    cpu_rd_req = 1'b0; cpu_rd_addr = 5'd31; rf[11] = 32'd7;
    exp_dv_q.push_back(32'd7);
    for (int i = 0; i < 70; i++) begin
      if (disp_value === 32'd7) break;
      tick(1);
    end
    check("refresh value", disp_value, 32'd7);
    exp_hex_q.push_back(7'b1111000);
    nib_sel = 3'd0;
    tick(2);

    // 6. reset mid-debounce with a starved pending read
    rf[3] = 32'h3C; rf[9] = 32'h99; sw = 5'd3; cpu_rd_req = 1'b1; cpu_rd_addr = 5'd20;
    tick(7);
    check("contention gnt", 32'(cpu_rd_gnt), 32'd1);
    sw = 5'd9;
    tick(3);
    reset = 1'b1; #1;
    check("mid reset disp_value", disp_value, 32'd0);
    check("mid reset disp_valid", 32'(disp_valid), 32'd0);
    check("mid reset HEX4", 32'(HEX4), 32'h40);
    check("mid reset gnt", 32'(cpu_rd_gnt), 32'd1);
    tick(2);
    reset = 1'b0; cyc = 0; #1;
    check("post reset raddr", 32'(rf_raddr), 32'd20);
    tick(3);
    check("post reset disp_valid busy", 32'(disp_valid), 32'd0);
    exp_dv_q.push_back(32'h99);
    exp_hex_q.push_back(7'b0010000);
    cpu_rd_req = 1'b0; cpu_rd_addr = 5'd31; #1;
    check("post reset idle raddr", 32'(rf_raddr), 32'd0);
    check("post reset idle gnt", 32'(cpu_rd_gnt), 32'd0);
    tick(1);
    check("post reset disp_valid", 32'(disp_valid), 32'd1);
    tick(8);
    check("disp queue drained", 32'(exp_dv_q.size()), 32'd0);
    check("hex queue drained", 32'(exp_hex_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
